// File: rtl/ring_arb_pkg.sv
// Shared types and helpers for the ring token arbiter: FSM state, one-hot/binary
// conversion and the ring successor rotation.
package ring_arb_pkg;

  // Widest requester vector the helper functions accept.
  localparam int unsigned MaxN = 32;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_GRANT
  } arb_state_e;

  // Token value after reset: bit n-1 set, so the highest index searches first.
  function automatic logic [MaxN-1:0] reset_token(input int unsigned n);
    return MaxN'(1) << (n - 1);
  endfunction

  function automatic int unsigned onehot_to_bin(input logic [MaxN-1:0] v);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MaxN; i++) begin
      if (v[i]) begin
        idx = idx | i;
      end
    end
    return idx;
  endfunction

  // Successor of index i is i-1; index 0 wraps to n-1. Bits above n-1 must be zero.
  function automatic logic [MaxN-1:0] rotate_right_1(input logic [MaxN-1:0] v,
                                                      input int unsigned n);
    logic [MaxN-1:0] r;
    r        = v >> 1;
    r[n - 1] = v[0];
    return r;
  endfunction

endpackage

// File: rtl/ring_priority_pick.sv
// Combinational round-robin pick: starting at the token index and walking downwards
// with wrap, returns the first requester as a one-hot vector and as a binary index.
module ring_priority_pick
  import ring_arb_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    token,
  output logic [N-1:0]    winner,
  output logic [ID_W-1:0] winner_id,
  output logic            any
);

  localparam logic [2*N-1:0] DblOne = {{(2 * N - 1) {1'b0}}, 1'b1};

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] mask;
  logic [2*N-1:0] hit;
  logic [2*N-1:0] top;

  always_comb begin
    dbl  = {req, req};
    // Keep every position at or below the token's slot in the upper copy; the
    // highest surviving bit is then the first requester in downward ring order.
    mask = ({token, {N{1'b0}}} << 1) - DblOne;
    hit  = dbl & mask;
    top  = '0;
    for (int unsigned j = 0; j < 2 * N; j++) begin
      if (hit[j]) begin
        top    = '0;
        top[j] = 1'b1;
      end
    end
    winner    = top[2*N-1:N] | top[N-1:0];
    winner_id = ID_W'(onehot_to_bin(MaxN'(winner)));
    any       = |req;
  end

endmodule

// File: rtl/ring_token_arbiter.sv
// Round-robin arbiter with a rotating one-hot token, bounded hold time under
// contention and a mandatory idle cycle between successive grants.
module ring_token_arbiter
  import ring_arb_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 4,
  localparam int unsigned ID_W    = $clog2(N),
  localparam int unsigned CNT_W   = $clog2(MAX_HOLD + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic            gnt_valid,
  output logic [ID_W-1:0] gnt_id,
  output logic [N-1:0]    token,
  output logic            preempt
);

  localparam logic [N-1:0]     TokenRst = N'(reset_token(N));
  localparam logic [CNT_W-1:0] HoldMax  = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HoldOne  = CNT_W'(1);

  arb_state_e       state_q, state_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
  logic [N-1:0]     token_q, token_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             preempt_q, preempt_d;

  logic [N-1:0]    pick_gnt;
  logic [ID_W-1:0] pick_id;
  logic            pick_any;
  logic [N-1:0]    owner_succ;
  logic            owner_req;
  logic            others_wait;

  ring_priority_pick #(
    .N(N)
  ) u_pick (
    .req      (req),
    .token    (token_q),
    .winner   (pick_gnt),
    .winner_id(pick_id),
    .any      (pick_any)
  );

  assign owner_succ  = N'(rotate_right_1(MaxN'(gnt_q), N));
  assign owner_req   = req[gnt_id_q];
  assign others_wait = |(req & ~gnt_q);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    hold_d    = hold_q;
    preempt_d = 1'b0;
    // A corrupted token heals to the reset pointer on the next edge.
    token_d   = $onehot(token_q) ? token_q : TokenRst;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_d    = pick_gnt;
          gnt_id_d = pick_id;
          hold_d   = HoldOne;
          state_d  = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!owner_req) begin
          gnt_d    = '0;
          gnt_id_d = '0;
          token_d  = owner_succ;
          hold_d   = '0;
          state_d  = ST_IDLE;
        end else if (hold_q == HoldMax && others_wait) begin
          gnt_d     = '0;
          gnt_id_d  = '0;
          token_d   = owner_succ;
          hold_d    = '0;
          preempt_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (hold_q != HoldMax) begin
          hold_d = hold_q + HoldOne;
        end
      end
      default: begin
        gnt_d    = '0;
        gnt_id_d = '0;
        hold_d   = '0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      token_q   <= TokenRst;
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      token_q   <= token_d;
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = |gnt_q;
  assign gnt_id    = gnt_id_q;
  assign token     = token_q;
  assign preempt   = preempt_q;

  gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));

endmodule
